cvxif_issuer: RTL

CVXIF_ISSUER -- requirements
Module: cvxif_issuer

---
 rtl/cvxif_issuer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cvxif_issuer.sv
// Issues one offloaded instruction at a time to a CV-X-IF style coprocessor
// and returns a single completion record (accept/writeback/timeout) to the core.
module cvxif_issuer #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        core_req_valid,
   output logic        core_req_ready,
   input  logic [31:0] core_req_instr,
   input  logic [31:0] core_req_rs0,
   input  logic [31:0] core_req_rs1,
   output logic        core_resp_valid,
   input  logic        core_resp_ready,
   output logic        core_resp_accept,
   output logic        core_resp_we,
   output logic        core_resp_timeout,
   output logic [4:0]  core_resp_rd,
   output logic [31:0] core_resp_data,
   output logic        issue_valid,
   input  logic        issue_ready,
   output logic [31:0] issue_req_instr,
   input  logic        issue_resp_accept,
   input  logic        issue_resp_writeback,
   input  logic [1:0]  issue_resp_register_read,
   output logic        register_valid,
   input  logic        register_ready,
   output logic [31:0] register_rs0,
   output logic [31:0] register_rs1,
   output logic [1:0]  register_rs_valid,
   input  logic        result_valid,
   output logic        result_ready,
   input  logic [31:0] result_data
);

   typedef enum logic [2:0] {IDLE, ISSUE, REG, RESULT, DONE} state_t;

   // Counter value seen on the last permitted wait cycle of a phase.
   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt_q;
   logic        accept_q, we_q, timeout_q, wb_q;
   logic [31:0] instr_q, rs0_q, rs1_q, data_q;
   logic [1:0]  rr_q;

   logic core_hs, issue_hs, reg_hs, res_hs, in_phase, phase_hs, expired;

   assign core_hs  = core_req_valid && (state_q == IDLE);
   assign issue_hs = issue_ready && (state_q == ISSUE);
   assign reg_hs   = register_ready && (state_q == REG);
   assign res_hs   = result_valid && (state_q == RESULT);
   assign in_phase = (state_q == ISSUE) || (state_q == REG) || (state_q == RESULT);
   assign phase_hs = issue_hs || reg_hs || res_hs;
   assign expired  = in_phase && !phase_hs && (wait_cnt_q == LAST_WAIT);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (core_req_valid) state_d = ISSUE;
         ISSUE: begin
            if (issue_ready) begin
               if (!issue_resp_accept)                  state_d = DONE;
               else if (issue_resp_register_read != '0) state_d = REG;
               else if (issue_resp_writeback)           state_d = RESULT;
               else                                     state_d = DONE;
            end else if (expired) begin
               state_d = DONE;
            end
         end
         REG: begin
            if (register_ready) state_d = wb_q ? RESULT : DONE;
            else if (expired)   state_d = DONE;
         end
         RESULT:  if (result_valid || expired) state_d = DONE;
         DONE:    if (core_resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         accept_q   <= 1'b0;
         we_q       <= 1'b0;
         timeout_q  <= 1'b0;
         wb_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q) wait_cnt_q <= '0;
         else if (in_phase)      wait_cnt_q <= wait_cnt_q + 8'd1;

         if (core_hs) begin
            accept_q  <= 1'b0;
            we_q      <= 1'b0;
            timeout_q <= 1'b0;
         end
         if (issue_hs) begin
            accept_q <= issue_resp_accept;
            wb_q     <= issue_resp_writeback;
         end
         if (res_hs) we_q <= 1'b1;
         // An abandoned phase reports neither acceptance nor a writeback.
         if (expired) begin
            timeout_q <= 1'b1;
            accept_q  <= 1'b0;
            we_q      <= 1'b0;
         end
      end
   end

   // Payload registers carry no reset; every output view of them is gated by state.
   always_ff @(posedge clk) begin
      if (core_hs) begin
         instr_q <= core_req_instr;
         rs0_q   <= core_req_rs0;
         rs1_q   <= core_req_rs1;
         data_q  <= '0;
      end
      if (issue_hs) rr_q <= issue_resp_register_read;
      if (res_hs)   data_q <= result_data;
   end

   assign core_req_ready    = (state_q == IDLE) && rst;
   assign issue_valid       = (state_q == ISSUE);
   assign issue_req_instr   = issue_valid ? instr_q : '0;
   assign register_valid    = (state_q == REG);
   assign register_rs0      = register_valid ? rs0_q : '0;
   assign register_rs1      = register_valid ? rs1_q : '0;
   assign register_rs_valid = register_valid ? rr_q : '0;
   assign result_ready      = (state_q == RESULT);
   assign core_resp_valid   = (state_q == DONE);
   assign core_resp_accept  = core_resp_valid && accept_q;
   assign core_resp_we      = core_resp_valid && we_q;
   assign core_resp_timeout = core_resp_valid && timeout_q;
   assign core_resp_rd      = core_resp_valid ? instr_q[11:7] : '0;
   assign core_resp_data    = core_resp_valid ? data_q : '0;

endmodule
